// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: memory-wait freeze, branch flush, load-use stall, timeout halt.
// Define HC_PERF_EN to add the stall/flush performance counters.
module hazard_ctrl_unit #(
  parameter int unsigned LU_BUBBLES  = 1,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk_HC,
  input  logic       rst_HC,
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic       rs1_used_ID,
  input  logic       rs2_used_ID,
  input  logic [4:0] rd_EX,
  input  logic       MemRead_EX,
  input  logic       branch_taken_EX,
  input  logic       mem_req_MEM,
  input  logic       mem_ready_MEM,
  output logic       en_PC,
  output logic       en_IFID,
  output logic       en_IDEX,
  output logic       en_EXMEM,
  output logic       en_MEMWB,
  output logic       NOP_IFID,
  output logic       NOP_IDEX,
  output logic       NOP_MEMWB,
  output logic       mem_err,
  output logic [1:0] state_HC
`ifdef HC_PERF_EN
  ,
  output logic [31:0] stall_cycles_HC,
  output logic [31:0] flush_cnt_HC
`endif
);

  typedef enum logic [1:0] {StRun = 2'd0, StBubble = 2'd1, StHalt = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        mem_err_q, mem_err_d;
  logic        lu, mw, halted;

  assign lu = MemRead_EX && (rd_EX != 5'd0) &&
              ((rs1_used_ID && (rs1_ID == rd_EX)) || (rs2_used_ID && (rs2_ID == rd_EX)));
  assign mw = mem_req_MEM && !mem_ready_MEM;
  // Encoding 3 is unused and treated as HALT.
  assign halted = state_q[1];

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    wcnt_d    = 16'd0;
    mem_err_d = mem_err_q;
    en_PC     = 1'b1;
    en_IFID   = 1'b1;
    en_IDEX   = 1'b1;
    en_EXMEM  = 1'b1;
    en_MEMWB  = 1'b1;
    NOP_IFID  = 1'b0;
    NOP_IDEX  = 1'b0;
    NOP_MEMWB = 1'b0;

    if (halted || mw) begin
      // Freeze the front of the pipe; drain a bubble into MEM/WB.
      en_PC     = 1'b0;
      en_IFID   = 1'b0;
      en_IDEX   = 1'b0;
      en_EXMEM  = 1'b0;
      NOP_MEMWB = 1'b1;
      if (!halted) begin
        wcnt_d = wcnt_q + 16'd1;
        if (wcnt_q == 16'(MEM_TIMEOUT - 1)) begin
          state_d   = StHalt;
          mem_err_d = 1'b1;
        end
      end
    end else if (branch_taken_EX) begin
      NOP_IFID = 1'b1;
      NOP_IDEX = 1'b1;
      state_d  = StRun;
      bcnt_d   = 2'd0;
    end else if (state_q == StBubble || lu) begin
      en_PC    = 1'b0;
      en_IFID  = 1'b0;
      NOP_IDEX = 1'b1;
      if (state_q == StBubble) begin
        bcnt_d = bcnt_q - 2'd1;
        if (bcnt_q == 2'd1) state_d = StRun;
      end else if (LU_BUBBLES > 1) begin
        state_d = StBubble;
        bcnt_d  = 2'(LU_BUBBLES - 1);
      end
    end

    if (rst_HC) begin
      en_PC     = 1'b0;
      en_IFID   = 1'b0;
      en_IDEX   = 1'b0;
      en_EXMEM  = 1'b0;
      en_MEMWB  = 1'b0;
      NOP_IFID  = 1'b0;
      NOP_IDEX  = 1'b0;
      NOP_MEMWB = 1'b0;
    end
  end

  always_ff @(posedge clk_HC or posedge rst_HC) begin
    if (rst_HC) begin
      state_q   <= StRun;
      bcnt_q    <= 2'd0;
      wcnt_q    <= 16'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err  = mem_err_q;
  assign state_HC = state_q;

`ifdef HC_PERF_EN
  logic [31:0] stall_q, flush_q;
  logic        flush_act;

  assign flush_act = !halted && !mw && branch_taken_EX;

  always_ff @(posedge clk_HC or posedge rst_HC) begin
    if (rst_HC) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (!halted && !en_PC) stall_q <= stall_q + 32'd1;
      if (flush_act)         flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles_HC = stall_q;
  assign flush_cnt_HC    = flush_q;
`endif

endmodule
